// File: rtl/iso7816_direction_detector.sv
// ISO7816 SIO direction detector: decides which probe tap drove each start bit,
// holds that decision for the frame and keeps saturating per-direction counters.
module iso7816_direction_detector #(
    parameter int SYNC_STAGES = 2,
    parameter int SKEW_MAX    = 8,
    parameter int IDLE_CYCLES = 16,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 clearCounters,
    input  logic                 termMon,
    input  logic                 cardMon,
    output logic                 dirTerm,
    output logic                 dirValid,
    output logic                 frameStart,
    output logic                 collision,
    output logic                 fault,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] termCount,
    output logic [CNT_WIDTH-1:0] cardCount,
    output logic [CNT_WIDTH-1:0] collisionCount
);
    // state  | meaning
    // IDLE   | waiting for IDLE_CYCLES of quiet line before arming
    // READY  | armed, watching for the first tap to fall
    // SKEW   | first tap low, waiting up to SKEW_MAX cycles for the second
    // ACTIVE | frame in progress, decision held until the line goes idle
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] READY  = 2'd1;
    localparam logic [1:0] SKEW   = 2'd2;
    localparam logic [1:0] ACTIVE = 2'd3;

    localparam int IDLE_W = $clog2(IDLE_CYCLES + 1);
    localparam int SKEW_W = $clog2(SKEW_MAX + 2);
    localparam logic [IDLE_W-1:0] IDLE_END = IDLE_W'(IDLE_CYCLES);
    localparam logic [SKEW_W-1:0] SKEW_END = SKEW_W'(SKEW_MAX);

    logic [SYNC_STAGES-1:0] termSync, cardSync;
    logic                   tS, cS;
    logic [1:0]             state, stateNext;
    logic [IDLE_W-1:0]      idleCnt, idleNext;
    logic [SKEW_W-1:0]      skewCnt, skewNext;
    logic                   firstTerm, firstNext, firstLow, secondLow, idleDone;
    logic                   decide, collide, faultHit, frameEnd;

    assign tS        = termSync[SYNC_STAGES-1];
    assign cS        = cardSync[SYNC_STAGES-1];
    assign firstLow  = firstTerm ? ~tS : ~cS;
    assign secondLow = firstTerm ? ~cS : ~tS;

    // Idle counting restarts while disabled so re-enabling needs a full quiet period.
    always_comb begin
        idleNext = '0;
        if (enable && tS && cS)
            idleNext = (idleCnt == IDLE_END) ? idleCnt : idleCnt + 1'b1;
    end
    assign idleDone = (idleNext == IDLE_END);

    always_comb begin
        stateNext = state;
        skewNext  = skewCnt;
        firstNext = firstTerm;
        decide    = 1'b0;
        collide   = 1'b0;
        faultHit  = 1'b0;
        frameEnd  = 1'b0;
        if (!enable) begin
            stateNext = IDLE;
        end else begin
            case (state)
                IDLE: if (idleDone) stateNext = READY;
                READY: begin
                    if (!tS && !cS) begin
                        collide   = 1'b1;
                        stateNext = ACTIVE;
                    end else if (!tS || !cS) begin
                        firstNext = ~tS;
                        skewNext  = '0;
                        stateNext = SKEW;
                    end
                end
                SKEW: begin
                    if (!firstLow || skewCnt == SKEW_END) begin
                        faultHit  = 1'b1;
                        stateNext = IDLE;
                    end else if (secondLow) begin
                        decide    = 1'b1;
                        stateNext = ACTIVE;
                    end else begin
                        skewNext = skewCnt + 1'b1;
                    end
                end
                ACTIVE: begin
                    if (idleDone) begin
                        frameEnd  = 1'b1;
                        stateNext = READY;
                    end
                end
                default: stateNext = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            termSync       <= '1;
            cardSync       <= '1;
            state          <= IDLE;
            idleCnt        <= '0;
            skewCnt        <= '0;
            firstTerm      <= 1'b0;
            dirTerm        <= 1'b0;
            dirValid       <= 1'b0;
            frameStart     <= 1'b0;
            collision      <= 1'b0;
            fault          <= 1'b0;
            busy           <= 1'b1;
            termCount      <= '0;
            cardCount      <= '0;
            collisionCount <= '0;
        end else begin
            termSync   <= {termSync[SYNC_STAGES-2:0], termMon};
            cardSync   <= {cardSync[SYNC_STAGES-2:0], cardMon};
            state      <= stateNext;
            idleCnt    <= idleNext;
            skewCnt    <= skewNext;
            firstTerm  <= firstNext;
            frameStart <= decide;
            collision  <= collide;
            fault      <= faultHit;
            busy       <= (stateNext != READY);
            if (decide)
                dirTerm <= firstTerm;
            if (!enable || frameEnd)
                dirValid <= 1'b0;
            else if (decide)
                dirValid <= 1'b1;
            if (clearCounters) begin
                termCount      <= '0;
                cardCount      <= '0;
                collisionCount <= '0;
            end else begin
                if (decide && firstTerm && termCount != '1)
                    termCount <= termCount + 1'b1;
                if (decide && !firstTerm && cardCount != '1)
                    cardCount <= cardCount + 1'b1;
                if (collide && collisionCount != '1)
                    collisionCount <= collisionCount + 1'b1;
            end
        end
    end
endmodule
